// File: rtl/muldiv_pkg.sv
// Shared types and constants for the execute-stage multiply sequencer.
// The pass order P0 -> P1 -> P2 is fixed; PNONE marks "no pass left".
package muldiv_pkg;

    localparam int HALF_W             = 16;
    localparam int DEFAULT_WAIT_LIMIT = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } mulseq_state_t;

    typedef enum logic [1:0] {
        P0    = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2,
        PNONE = 2'd3
    } mul_pass_t;

    function automatic mul_pass_t pass_after(input mul_pass_t p);
        case (p)
            P0:      return P1;
            P1:      return P2;
            default: return PNONE;
        endcase
    endfunction

endpackage

// File: rtl/mul_pass_select.sv
// Picks the first pass at or after from_pass whose 16-bit operands are both
// non-zero, and returns that pass's zero-extended operands and result shift.
module mul_pass_select
    import muldiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  from_pass,
    output logic [1:0]  pass,
    output logic [31:0] mcand,
    output logic [31:0] mplier,
    output logic [4:0]  shift
);

    logic [HALF_W-1:0] a_lo_s;
    logic [HALF_W-1:0] a_hi_s;
    logic [HALF_W-1:0] b_lo_s;
    logic [HALF_W-1:0] b_hi_s;
    logic [2:0]        run_s;
    mul_pass_t         sel_s;

    assign a_lo_s = a[HALF_W-1:0];
    assign a_hi_s = a[31:HALF_W];
    assign b_lo_s = b[HALF_W-1:0];
    assign b_hi_s = b[31:HALF_W];

    // A pass only runs when neither of its half-word operands is zero.
    always_comb begin
        run_s    = 3'b000;
        run_s[0] = (|a_lo_s) & (|b_lo_s);
        run_s[1] = (|a_hi_s) & (|b_lo_s);
        run_s[2] = (|a_lo_s) & (|b_hi_s);
    end

    // Priority search for the next runnable pass, starting at from_pass.
    always_comb begin
        sel_s = PNONE;
        case (mul_pass_t'(from_pass))
            P0: begin
                if (run_s[0])      sel_s = P0;
                else if (run_s[1]) sel_s = P1;
                else if (run_s[2]) sel_s = P2;
                else               sel_s = PNONE;
            end
            P1: begin
                if (run_s[1])      sel_s = P1;
                else if (run_s[2]) sel_s = P2;
                else               sel_s = PNONE;
            end
            P2: begin
                if (run_s[2]) sel_s = P2;
                else          sel_s = PNONE;
            end
            default: sel_s = PNONE;
        endcase
    end

    // Operand and shift decode for the selected pass.
    always_comb begin
        mcand  = 32'd0;
        mplier = 32'd0;
        shift  = 5'd0;
        case (sel_s)
            P0: begin
                mcand  = {{HALF_W{1'b0}}, a_lo_s};
                mplier = {{HALF_W{1'b0}}, b_lo_s};
                shift  = 5'd0;
            end
            P1: begin
                mcand  = {{HALF_W{1'b0}}, a_hi_s};
                mplier = {{HALF_W{1'b0}}, b_lo_s};
                shift  = 5'd16;
            end
            P2: begin
                mcand  = {{HALF_W{1'b0}}, a_lo_s};
                mplier = {{HALF_W{1'b0}}, b_hi_s};
                shift  = 5'd16;
            end
            default: begin
                mcand  = 32'd0;
                mplier = 32'd0;
                shift  = 5'd0;
            end
        endcase
    end

    assign pass = sel_s;

endmodule

// File: rtl/mul_sequencer.sv
// Splits a 32x32 MUL into up to three 16x16 passes on the shared multiplier
// and returns the low 32 bits of the product through a valid/ready response.
module mul_sequencer
    import muldiv_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        busy,
    output logic        mul_o,
    output logic [31:0] mcand_o,
    output logic [31:0] mplier_o,
    input  logic [31:0] mul_product_i,
    input  logic        mul_ack_i
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    mulseq_state_t     state_r;
    mulseq_state_t     state_nxt_s;
    mul_pass_t         pass_r;
    mul_pass_t         from_s;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [4:0]        rd_r;
    logic [4:0]        shift_r;
    logic [31:0]       acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       mcand_r;
    logic [31:0]       mplier_r;
    logic [31:0]       resp_result_r;
    logic [4:0]        resp_rd_r;
    logic              resp_err_r;

    logic [31:0]       a_sel_s;
    logic [31:0]       b_sel_s;
    logic [1:0]        sel_pass_raw_s;
    mul_pass_t         sel_pass_s;
    logic [31:0]       sel_mcand_s;
    logic [31:0]       sel_mplier_s;
    logic [4:0]        sel_shift_s;
    logic [31:0]       acc_sum_s;
    logic              accept_s;
    logic              ack_s;
    logic              timeout_s;

    // In IDLE the selector looks at the incoming request; afterwards at the
    // captured operands, resuming after the pass that just completed.
    assign a_sel_s    = (state_r == IDLE) ? req_rs1 : a_r;
    assign b_sel_s    = (state_r == IDLE) ? req_rs2 : b_r;
    assign from_s     = (state_r == IDLE) ? P0 : pass_after(pass_r);
    assign sel_pass_s = mul_pass_t'(sel_pass_raw_s);
    assign acc_sum_s  = acc_r + (mul_product_i << shift_r);

    mul_pass_select u_pass_select (
        .a         (a_sel_s),
        .b         (b_sel_s),
        .from_pass (from_s),
        .pass      (sel_pass_raw_s),
        .mcand     (sel_mcand_s),
        .mplier    (sel_mplier_s),
        .shift     (sel_shift_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state and control strobes; flush wins over everything, and ack is
    // only looked at in WAIT because it may still be high from the last pass.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ack_s       = 1'b0;
        timeout_s   = 1'b0;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = (sel_pass_s != PNONE) ? LAUNCH : DONE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LAUNCH: state_nxt_s = WAIT;
                WAIT: begin
                    if (mul_ack_i) begin
                        ack_s       = 1'b1;
                        state_nxt_s = (sel_pass_s != PNONE) ? LAUNCH : DONE;
                    end else if (cnt_r == CNT_W'(WAIT_LIMIT - 1)) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DONE: begin
                    if (resp_ready) state_nxt_s = IDLE;
                    else            state_nxt_s = DONE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Operand capture, pass tracking, accumulation, wait counter and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            rd_r          <= 5'd0;
            pass_r        <= PNONE;
            shift_r       <= 5'd0;
            acc_r         <= 32'd0;
            cnt_r         <= {CNT_W{1'b0}};
            mcand_r       <= 32'd0;
            mplier_r      <= 32'd0;
            resp_result_r <= 32'd0;
            resp_rd_r     <= 5'd0;
            resp_err_r    <= 1'b0;
        end else if (accept_s) begin
            a_r        <= req_rs1;
            b_r        <= req_rs2;
            rd_r       <= req_rd;
            acc_r      <= 32'd0;
            cnt_r      <= {CNT_W{1'b0}};
            pass_r     <= sel_pass_s;
            shift_r    <= sel_shift_s;
            mcand_r    <= sel_mcand_s;
            mplier_r   <= sel_mplier_s;
            resp_err_r <= 1'b0;
            if (sel_pass_s == PNONE) begin
                resp_result_r <= 32'd0;
                resp_rd_r     <= req_rd;
            end
        end else if (ack_s) begin
            acc_r    <= acc_sum_s;
            cnt_r    <= {CNT_W{1'b0}};
            pass_r   <= sel_pass_s;
            shift_r  <= sel_shift_s;
            mcand_r  <= sel_mcand_s;
            mplier_r <= sel_mplier_s;
            if (sel_pass_s == PNONE) begin
                resp_result_r <= acc_sum_s;
                resp_rd_r     <= rd_r;
                resp_err_r    <= 1'b0;
            end
        end else if (timeout_s) begin
            cnt_r         <= {CNT_W{1'b0}};
            resp_result_r <= 32'd0;
            resp_rd_r     <= rd_r;
            resp_err_r    <= 1'b1;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign req_ready   = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign mul_o       = (state_r == LAUNCH);
    assign resp_valid  = (state_r == DONE);
    assign resp_result = resp_result_r;
    assign resp_rd     = resp_rd_r;
    assign resp_err    = resp_err_r;
    assign mcand_o     = mcand_r;
    assign mplier_o    = mplier_r;

endmodule
